fft_output_sink: RTL
====================

FFT_OUTPUT_SINK -- requirements
Module: fft_output_sink

Interface
REQ-001 SHALL have parameter FFT_POINTS, default 14'd8192, meaning the frame length in samples (power of two, 64..8192).
REQ-002 SHALL have parameter DATA_W, default 12, meaning the width of each real/imag output sample of the FFT core.
REQ-003 SHALL have one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 source_valid  input  1  FFT output beat valid.
REQ-007 source_sop  input  1  first beat of a frame.
REQ-008 source_eop  input  1  last beat of a frame.
REQ-009 source_error  input  2  core error code; nonzero marks the frame bad.
REQ-010 source_real  input  DATA_W  signed real part.
REQ-011 source_imag  input  DATA_W  signed imaginary part.
REQ-012 source_ready  output  1  sink may accept a beat.
REQ-013 result_valid  output  1  peak result available.
REQ-014 result_ready  input  1  downstream accepts result.
REQ-015 peak_index  output  $clog2(FFT_POINTS)  bin of maximum power.
REQ-016 peak_power  output  2*DATA_W+1  re^2+im^2 of peak bin, unsigned.
REQ-017 frame_err  output  1  result frame had a framing or core error.
REQ-018 frame_count  output  16  count of completed frames, wraps at 65535->0.

Function
REQ-019 A beat SHALL be accepted only when source_valid && source_ready; other cycles SHALL not change state.
REQ-020 States SHALL be IDLE (await sop), RECV (collect beats), HOLD (result pending); reset state IDLE.
REQ-021 IDLE: beats without sop SHALL be discarded; accepted sop beat SHALL be bin 0 and move to RECV.
REQ-022 Power SHALL be computed full-width (2*DATA_W+1 bits, no truncation) in one register stage, so a bin's compare happens one cycle after acceptance.
REQ-023 Peak SHALL be strict greater-than; ties keep the lowest index.
REQ-024 Accepted eop at bin FFT_POINTS-1 SHALL end frame cleanly; result_valid SHALL assert exactly 2 cycles after that acceptance cycle, state HOLD.
REQ-025 eop before bin FFT_POINTS-1 SHALL end the frame with frame_err=1.
REQ-026 Bin FFT_POINTS-1 without eop SHALL end the frame with frame_err=1; subsequent beats SHALL be discarded until a sop.
REQ-027 sop accepted in RECV SHALL abort the current frame (no result) and start a new frame with that beat as bin 0.
REQ-028 Any accepted beat with source_error!=0 SHALL set frame_err for that frame.
REQ-029 source_ready SHALL be 1 in IDLE and RECV, 0 from frame end until result handshake completes.
REQ-030 Result outputs SHALL be held stable while result_valid && !result_ready; handshake SHALL return to IDLE and increment frame_count the next cycle.

Reset
REQ-031 Asserting rst at any time, including mid-frame, SHALL immediately force IDLE, source_ready=0, result_valid=0, peak_index=0, peak_power=0, frame_err=0, frame_count=0, discarding any partial frame.
REQ-032 source_ready SHALL rise on the first clk edge after rst deasserts.

Configuration
REQ-033 Macro FFT_SINK_DC_SKIP_EN defined: bin 0 SHALL be excluded from the peak search (peak starts at bin 1); undefined: bin 0 SHALL participate.

Structure
REQ-034 Shared package fft_pkg SHALL hold the state enum, the default FFT_POINTS/DATA_W constants and the power width function.
REQ-035 Sub-module fft_power_calc SHALL implement the registered re^2+im^2 stage; all other logic in fft_output_sink.

Verification
REQ-036 FFT_POINTS=64, clean frame, bin 5 = (100,-50) and others 0 -> result_valid 2 cycles after eop, peak_index=5, peak_power=12500, frame_err=0.
REQ-037 Bins 3 and 9 both (200,0) -> peak_index=3, peak_power=40000.
REQ-038 eop on bin 40 of 64 -> frame_err=1, source_ready=0 until result_ready handshake, frame_count increments by 1.
REQ-039 sop reasserted at bin 20, then clean 64-bin frame with peak at bin 7 -> exactly one result, peak_index=7, frame_err=0.
REQ-040 result_ready held 0 for 10 cycles -> outputs stable, source_ready=0, beats offered are not accepted; rst pulse mid-frame -> all outputs 0, IDLE.
REQ-041 bin 0 = (2047,0), bin 4 = (10,10): with FFT_SINK_DC_SKIP_EN peak_index=4, peak_power=200; without, peak_index=0, peak_power=4190209.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output sink: sink state encoding, default
// frame/sample sizes and the width of an unsigned re^2+im^2 power value.
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RECV = 2'd1,
        ST_HOLD = 2'd2
    } sink_state_t;

    localparam int DEF_FFT_POINTS = 14'd8192;
    localparam int DEF_DATA_W     = 12;

    // Full-width power: two squared signed samples summed without truncation.
    function automatic int power_width(input int data_w);
        return (32'sd2 * data_w) + 32'sd1;
    endfunction

endpackage

// File: rtl/fft_output_sink_if.sv
// FFT core output stream plus peak-result handshake; the slave modport is the
// sink's view, the master modport the view of the core/downstream side.
interface fft_output_sink_if #(
    parameter int FFT_POINTS = fft_pkg::DEF_FFT_POINTS,
    parameter int DATA_W     = fft_pkg::DEF_DATA_W
);
    import fft_pkg::*;

    localparam int IDX_W = $clog2(FFT_POINTS);
    localparam int PW_W  = power_width(DATA_W);

    logic                     source_valid;
    logic                     source_sop;
    logic                     source_eop;
    logic [1:0]               source_error;
    logic signed [DATA_W-1:0] source_real;
    logic signed [DATA_W-1:0] source_imag;
    logic                     source_ready;

    logic                     result_valid;
    logic                     result_ready;
    logic [IDX_W-1:0]         peak_index;
    logic [PW_W-1:0]          peak_power;
    logic                     frame_err;
    logic [15:0]              frame_count;

    modport slave (
        input  source_valid, source_sop, source_eop, source_error,
        input  source_real, source_imag, result_ready,
        output source_ready, result_valid, peak_index, peak_power,
        output frame_err, frame_count
    );

    modport master (
        output source_valid, source_sop, source_eop, source_error,
        output source_real, source_imag, result_ready,
        input  source_ready, result_valid, peak_index, peak_power,
        input  frame_err, frame_count
    );

endinterface

// File: rtl/fft_power_calc.sv
// Registered power stage: out_power = re^2 + im^2 at full width, one cycle
// after in_valid.
module fft_power_calc
    import fft_pkg::*;
#(
    parameter  int DATA_W = DEF_DATA_W,
    localparam int PW_W   = power_width(DATA_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_real,
    input  logic signed [DATA_W-1:0] in_imag,
    output logic                     out_valid,
    output logic [PW_W-1:0]          out_power
);

    logic signed [2*DATA_W-1:0] re_ext_s;
    logic signed [2*DATA_W-1:0] im_ext_s;
    logic signed [2*DATA_W-1:0] re_sq_s;
    logic signed [2*DATA_W-1:0] im_sq_s;
    logic [PW_W-1:0]            power_s;

    // Squares are never negative and fit 2*DATA_W bits even for the most negative input.
    always_comb begin
        re_ext_s = {{DATA_W{in_real[DATA_W-1]}}, in_real};
        im_ext_s = {{DATA_W{in_imag[DATA_W-1]}}, in_imag};
        re_sq_s  = re_ext_s * re_ext_s;
        im_sq_s  = im_ext_s * im_ext_s;
        power_s  = {1'b0, re_sq_s} + {1'b0, im_sq_s};
    end

    // Power register stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_power <= {PW_W{1'b0}};
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_power <= power_s;
            end
        end
    end

endmodule

// File: rtl/fft_output_sink.sv
// Collects one FFT frame, finds the bin of maximum power and presents it on a
// valid/ready result port. Define FFT_SINK_DC_SKIP_EN to exclude bin 0.
module fft_output_sink
    import fft_pkg::*;
#(
    parameter int FFT_POINTS = DEF_FFT_POINTS,
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    fft_output_sink_if.slave  bus
);

    localparam int IDX_W = $clog2(FFT_POINTS);
    localparam int PW_W  = power_width(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_POINTS - 32'sd1);
    localparam logic [IDX_W-1:0] ZERO_IDX = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(32'sd1);

    sink_state_t      state_r;
    sink_state_t      state_next_s;
    logic             accept_s;
    logic             take_beat_s;
    logic             start_s;
    logic             end_s;
    logic             clean_end_s;
    logic             beat_err_s;
    logic [IDX_W-1:0] beat_idx_s;
    logic [IDX_W-1:0] bin_r;
    logic [IDX_W-1:0] pw_idx_r;
    logic             pw_last_r;
    logic             pw_valid_s;
    logic [PW_W-1:0]  pw_power_s;
    logic             eligible_s;
    logic             take_peak_s;
    logic             have_peak_r;
    logic [IDX_W-1:0] acc_idx_r;
    logic [PW_W-1:0]  acc_power_r;
    logic             err_acc_r;
    logic             source_ready_r;
    logic             result_valid_r;
    logic [IDX_W-1:0] peak_index_r;
    logic [PW_W-1:0]  peak_power_r;
    logic             frame_err_r;
    logic [15:0]      frame_count_r;

    // Beat qualification: a sop beat is always bin 0, otherwise the running bin counter.
    always_comb begin
        accept_s    = bus.source_valid && source_ready_r;
        beat_idx_s  = bus.source_sop ? ZERO_IDX : bin_r;
        take_beat_s = accept_s && ((state_r == ST_RECV) ||
                                   ((state_r == ST_IDLE) && bus.source_sop));
        start_s     = take_beat_s && bus.source_sop;
        end_s       = bus.source_eop || (beat_idx_s == LAST_IDX);
        clean_end_s = bus.source_eop && (beat_idx_s == LAST_IDX);
        beat_err_s  = (bus.source_error != 2'b00);
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_RECV: begin
                if (take_beat_s) begin
                    if (end_s) begin
                        state_next_s = ST_HOLD;
                    end else begin
                        state_next_s = ST_RECV;
                    end
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_HOLD: begin
                if (result_valid_r && bus.result_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register; ready follows the next state so it is low throughout reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            source_ready_r <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            source_ready_r <= (state_next_s != ST_HOLD);
        end
    end

    fft_power_calc #(
        .DATA_W (DATA_W)
    ) u_power_calc (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (take_beat_s),
        .in_real   (bus.source_real),
        .in_imag   (bus.source_imag),
        .out_valid (pw_valid_s),
        .out_power (pw_power_s)
    );

    // Peak candidate: first eligible bin seeds the search, later ones must be strictly larger.
    always_comb begin
`ifdef FFT_SINK_DC_SKIP_EN
        eligible_s = (pw_idx_r != ZERO_IDX);
`else
        eligible_s = 1'b1;
`endif
        take_peak_s = pw_valid_s && eligible_s &&
                      (!have_peak_r || (pw_power_s > acc_power_r));
    end

    // Frame tracking and running peak; a new sop drops any bin still in the power stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_r       <= ZERO_IDX;
            pw_idx_r    <= ZERO_IDX;
            pw_last_r   <= 1'b0;
            err_acc_r   <= 1'b0;
            have_peak_r <= 1'b0;
            acc_idx_r   <= ZERO_IDX;
            acc_power_r <= {PW_W{1'b0}};
        end else begin
            pw_last_r <= take_beat_s && end_s;
            if (take_beat_s) begin
                bin_r     <= beat_idx_s + ONE_IDX;
                pw_idx_r  <= beat_idx_s;
                err_acc_r <= (err_acc_r && !start_s) || beat_err_s || (end_s && !clean_end_s);
            end
            if (start_s) begin
                have_peak_r <= 1'b0;
                acc_idx_r   <= ZERO_IDX;
                acc_power_r <= {PW_W{1'b0}};
            end else if (take_peak_s) begin
                have_peak_r <= 1'b1;
                acc_idx_r   <= pw_idx_r;
                acc_power_r <= pw_power_s;
            end
        end
    end

    // Result port: publish once the last bin has been compared, count on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_valid_r <= 1'b0;
            peak_index_r   <= ZERO_IDX;
            peak_power_r   <= {PW_W{1'b0}};
            frame_err_r    <= 1'b0;
            frame_count_r  <= 16'd0;
        end else if (pw_valid_s && pw_last_r) begin
            result_valid_r <= 1'b1;
            peak_index_r   <= take_peak_s ? pw_idx_r : acc_idx_r;
            peak_power_r   <= take_peak_s ? pw_power_s : acc_power_r;
            frame_err_r    <= err_acc_r;
        end else if (result_valid_r && bus.result_ready) begin
            result_valid_r <= 1'b0;
            frame_count_r  <= frame_count_r + 16'd1;
        end
    end

    assign bus.source_ready = source_ready_r;
    assign bus.result_valid = result_valid_r;
    assign bus.peak_index   = peak_index_r;
    assign bus.peak_power   = peak_power_r;
    assign bus.frame_err    = frame_err_r;
    assign bus.frame_count  = frame_count_r;

endmodule
